// File: rtl/gray_stream_ctrl.sv
// gray_stream_ctrl
//
// Sequencing controller for an external RGB-to-luma datapath. Upstream
// pixels are accepted through a valid/ready handshake, presented to the
// datapath on dp_R/G/B with all stage enables high, and the returned luma
// is saturated to 8 bits and queued in a first-word-fall-through output FIFO.
// Admission is credit based: a pixel is only accepted when the FIFO is
// guaranteed to have room for it by the time its result comes back.
//
// Timing contract with the datapath: dp_Y must hold the result of a pixel
// LAT cycles after the cycle in which that pixel was accepted. That is,
// LAT-1 rising edges after it appears on dp_R/G/B.
//
// Parameters
//   LAT    accept-to-result latency in cycles (2..31)
//   DEPTH  output FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, stop             single-cycle run / stop requests
//   in_valid, in_ready      upstream handshake, in_r/in_g/in_b pixel data
//   dp_R, dp_G, dp_B        pixel presented to the datapath
//   dp_i2pEn .. dp_f2iEn    datapath stage enables
//   dp_Y                    32-bit integer luma from the datapath
//   out_valid, out_ready    downstream handshake, out_y saturated luma
//   busy                    high while running or draining
//   inflight                pixels currently inside the datapath
//   sat_cnt                 (GRAY_SAT_CNT_EN only) count of saturated results
//
// Optional feature: define GRAY_SAT_CNT_EN to add the sat_cnt output.
//
// FSM states
//   state | meaning
//   IDLE  | enables low, no input accepted, FIFO still drainable
//   RUN   | enables high, accepting pixels while credit allows
//   DRAIN | enables high, no new input, waiting for inflight to reach 0

module gray_stream_ctrl #(
    parameter int LAT   = 14,
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  dp_R,
    output logic [7:0]  dp_G,
    output logic [7:0]  dp_B,
    output logic        dp_i2pEn,
    output logic        dp_mulEn,
    output logic        dp_addEn,
    output logic        dp_f2iEn,
    input  logic [31:0] dp_Y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_y,
    output logic        busy,
    output logic [4:0]  inflight
`ifdef GRAY_SAT_CNT_EN
    ,
    output logic [15:0] sat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    // Wide enough to hold fifo_count + inflight without overflow.
    localparam int SW = (AW + 2 > 6) ? (AW + 2) : 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            dp_en;

    logic [LAT-1:0]  vld_sr;
    logic            tail;
    logic            accept;
    logic            push;
    logic            pop;
    logic            y_over;
    logic [7:0]      y_sat;

    logic [7:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_count;
    logic [SW-1:0]   credit_used;

    // ------------------------------------------------------------------
    // Handshake and credit
    // ------------------------------------------------------------------
    assign credit_used = SW'(fifo_count) + SW'(inflight);
    assign in_ready    = (state == RUN) && (credit_used < SW'(DEPTH));
    assign accept      = in_valid && in_ready;

    assign tail   = vld_sr[LAT-1];
    assign y_over = (dp_Y > 32'd255);
    assign y_sat  = y_over ? 8'hFF : dp_Y[7:0];

    // Credit admission guarantees a free slot for every tail, or a pop in
    // the same cycle when the FIFO is full.
    assign push = tail;
    assign pop  = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop)     state_nxt = RUN;
            RUN:     if (stop)               state_nxt = DRAIN;
            DRAIN:   if (inflight == 5'd0)   state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // dp_en and busy follow the next state so they are registered yet
    // aligned with the state register. DRAIN only exits at inflight == 0,
    // so the enables can never fall with pixels still in the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dp_en <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            dp_en <= (state_nxt != IDLE);
            busy  <= (state_nxt != IDLE);
        end
    end

    assign dp_i2pEn = dp_en;
    assign dp_mulEn = dp_en;
    assign dp_addEn = dp_en;
    assign dp_f2iEn = dp_en;

    // ------------------------------------------------------------------
    // Pixel register toward the datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_R <= 8'h00;
            dp_G <= 8'h00;
            dp_B <= 8'h00;
        end else if (accept) begin
            dp_R <= in_r;
            dp_G <= in_g;
            dp_B <= in_b;
        end
    end

    // ------------------------------------------------------------------
    // Valid tracking. inflight is kept as a counter that always equals the
    // popcount of vld_sr: +1 on accept, -1 on tail, unchanged on both.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            inflight <= 5'd0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], accept};
            case ({accept, tail})
                2'b10:   inflight <= inflight + 5'd1;
                2'b01:   inflight <= inflight - 5'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through). Pointers wrap naturally since
    // DEPTH is a power of two.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: out_y is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= y_sat;
    end

    assign out_valid = (fifo_count != '0);
    assign out_y     = out_valid ? fifo_mem[rd_ptr] : 8'h00;

`ifdef GRAY_SAT_CNT_EN
    // ------------------------------------------------------------------
    // Saturation event counter, cleared by an effective start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 16'h0000;
        end else if (state == IDLE && start && !stop) begin
            sat_cnt <= 16'h0000;
        end else if (push && y_over && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_stream_ctrl.sv
module tb_gray_stream_ctrl;

    localparam int LAT   = 14;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r, in_g, in_b;
    logic [7:0]  dp_R, dp_G, dp_B;
    logic        dp_i2pEn, dp_mulEn, dp_addEn, dp_f2iEn;
    logic [31:0] dp_Y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;
    logic        busy;
    logic [4:0]  inflight;
`ifdef GRAY_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    gray_stream_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .dp_R      (dp_R),
        .dp_G      (dp_G),
        .dp_B      (dp_B),
        .dp_i2pEn  (dp_i2pEn),
        .dp_mulEn  (dp_mulEn),
        .dp_addEn  (dp_addEn),
        .dp_f2iEn  (dp_f2iEn),
        .dp_Y      (dp_Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy),
        .inflight  (inflight)
`ifdef GRAY_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int n_pop    = 0;
    int first_acc_cyc = -1;
    logic raw_mode = 1'b0;

    logic [7:0] exp_q [$];
    logic [7:0] out_hist [$];
    int         pop_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath behaviour. Normal mode is the integer luma formula; raw mode
    // returns {G,R} so results above 255 can be produced on demand.
    function automatic logic [31:0] dp_func(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b, input logic raw);
        if (raw) return {16'h0000, g, r};
        return (32'd77 * r + 32'd150 * g + 32'd29 * b) >> 8;
    endfunction

    function automatic logic [7:0] sat8(input logic [31:0] y);
        return (y > 32'd255) ? 8'hFF : y[7:0];
    endfunction

    // Datapath model: result available LAT cycles after the accept cycle.
    logic [31:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= dp_func(dp_R, dp_G, dp_B, raw_mode);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_Y = pipe[LAT-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected pushed on accept, popped and compared on output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(sat8(dp_func(in_r, in_g, in_b, raw_mode)));
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_y), 32'hFFFF_FFFF);
                end else begin
                    check("out_y_order", 32'(out_y), 32'(exp_q.pop_front()));
                end
                out_hist.push_back(out_y);
                pop_cyc.push_back(cyc);
                n_pop++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int k = 0;
        while (n_pop < target && k < budget) begin tick(1); k++; end
        check(name, 32'(n_pop), 32'(target));
    endtask

    // Offer random pixels until n are accepted or the cycle budget expires.
    task automatic send(input int n, input int budget, output int got);
        logic acc;
        int k = 0;
        got = 0;
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
        in_valid = 1'b1;
        while (got < n && k < budget) begin
            @(negedge clk); acc = in_ready;
            tick(1); k++;
            if (acc) begin
                got++;
                in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic acc = 1'b0;
        int k = 0;
        in_r = r; in_g = g; in_b = b; in_valid = 1'b1;
        while (!acc && k < 50) begin
            @(negedge clk); acc = in_ready;
            tick(1); k++;
        end
        in_valid = 1'b0;
        check("send_px_accepted", 32'(acc), 32'd1);
    endtask

    function automatic logic [3:0] ens();
        return {dp_i2pEn, dp_mulEn, dp_addEn, dp_f2iEn};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, p0, k, bad;
        logic acc;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        in_r = 8'h00; in_g = 8'h00; in_b = 8'h00; out_ready = 1'b0;
        tick(3);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_en",        32'(ens()),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y",     32'(out_y),     32'd0);
        check("rst_inflight",  32'(inflight),  32'd0);
        check("rst_dp_rgb",    32'({dp_R, dp_G, dp_B}), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_wait_busy", 32'(busy), 32'd0);

        // start and stop together in IDLE: stay IDLE
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        tick(2);
        check("start_stop_busy", 32'(busy), 32'd0);
        check("start_stop_en",   32'(ens()), 32'd0);

        // Streaming, 100 pixels, no backpressure
        out_ready = 1'b1;
        pulse_start();
        check("run_busy", 32'(busy), 32'd1);
        check("run_en",   32'(ens()), 32'hF);
        first_acc_cyc = -1;
        pop_cyc.delete();
        p0 = n_pop;
        send(100, 300, got);
        check("stream_accepted", 32'(got), 32'd100);
        wait_pops("stream_outputs", p0 + 100, 200);
        if (pop_cyc.size() >= 100) begin
            check("stream_latency", 32'(pop_cyc[0] - first_acc_cyc), 32'(1 + LAT));
            check("stream_no_bubble", 32'(pop_cyc[99] - pop_cyc[0]), 32'd99);
        end else begin
            check("stream_pop_count", 32'(pop_cyc.size()), 32'd100);
        end
        pulse_stop();
        wait_idle("stream_drain_idle", 100);
        check("stream_idle_en", 32'(ens()), 32'd0);

        // Backpressure: credit stops intake at DEPTH
        out_ready = 1'b0;
        pulse_start();
        p0 = n_pop;
        send(40, 40, got);
        check("bp_accepted", 32'(got), 32'(DEPTH));
        tick(LAT + 4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_full_valid",   32'(out_valid), 32'd1);
        // Full FIFO with push and pop together: data order via scoreboard
        out_ready = 1'b1;
        send(30, 200, got);
        check("bp_full_stream", 32'(got), 32'd30);
        wait_pops("bp_delivered", p0 + DEPTH + 30, 200);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Random valid/ready traffic
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk); acc = in_valid && in_ready;
            tick(1);
            if (acc) begin
                in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 200) begin tick(1); k++; end
        check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
        pulse_stop();
        wait_idle("rand_idle", 100);

        // Saturation
        raw_mode = 1'b1;
        pulse_start();
        p0 = n_pop;
        send_px(8'h2C, 8'h01, 8'h00);   // 300
        send_px(8'hFF, 8'h00, 8'h00);   // 255
        send_px(8'h00, 8'h00, 8'h00);   // 0
        pulse_stop();
        wait_idle("sat_idle", 100);
        wait_pops("sat_outputs", p0 + 3, 20);
        if (out_hist.size() >= 3) begin
            check("sat_y0", 32'(out_hist[out_hist.size()-3]), 32'd255);
            check("sat_y1", 32'(out_hist[out_hist.size()-2]), 32'd255);
            check("sat_y2", 32'(out_hist[out_hist.size()-1]), 32'd0);
        end
`ifdef GRAY_SAT_CNT_EN
        check("sat_cnt", 32'(sat_cnt), 32'd1);
`endif
        raw_mode = 1'b0;

        // Stop and drain with results held in the FIFO
        out_ready = 1'b0;
        pulse_start();
        p0 = n_pop;
        send(5, 50, got);
        check("drain_accepted", 32'(got), 32'd5);
        pulse_stop();
        check("drain_in_ready", 32'(in_ready), 32'd0);
        check("drain_busy",     32'(busy),     32'd1);
        bad = 0; k = 0;
        while (busy && k < 60) begin
            if (inflight != 5'd0 && ens() != 4'hF) bad++;
            tick(1); k++;
        end
        check("drain_en_held", 32'(bad), 32'd0);
        check("drain_idle",    32'(busy), 32'd0);
        check("drain_idle_en", 32'(ens()), 32'd0);
        check("drain_inflight", 32'(inflight), 32'd0);
        out_ready = 1'b1;
        tick(10);
        check("drain_fifo_yield", 32'(n_pop - p0), 32'd5);

        // Reset in mid-operation
        out_ready = 1'b0;
        pulse_start();
        send(10, 20, got);
        k = 0;
        while (!(inflight == 5'd7 && out_valid) && k < 40) begin tick(1); k++; end
        check("mid_reached_7_3", 32'(inflight), 32'd7);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_en",        32'(ens()),     32'd0);
        check("mid_rst_inflight",  32'(inflight),  32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_y",     32'(out_y),     32'd0);
        check("mid_rst_dp_rgb",    32'({dp_R, dp_G, dp_B}), 32'd0);
        tick(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (out_valid || busy) bad++;
        end
        check("mid_no_ghost_output", 32'(bad), 32'd0);
        p0 = n_pop;
        pulse_start();
        send(1, 20, got);
        wait_pops("mid_restart_output", p0 + 1, 40);
        pulse_stop();
        wait_idle("mid_final_idle", 100);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
